// File: rtl/boot_loader_if.sv
// Byte-stream loader bus bundle.
//   rx_data/rx_valid/rx_ready : host -> loader byte channel (valid/ready)
//   im_we/im_waddr/im_wdata   : loader -> instruction memory write port
// master: host / memory side; slave: the loader itself.
interface boot_loader_if #(
    parameter int IM_AW = 10
) ();
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             im_we;
    logic [IM_AW-1:0] im_waddr;
    logic [31:0]      im_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_waddr, im_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream program loader. Holds the core in reset, receives a
// length-prefixed (16-bit little-endian word count) image, packs bytes
// little-endian into 32-bit words, writes them to instruction memory and
// then releases the core after RST_HOLD cycles.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load_req      : request (re)load, honoured in IDLE and ERROR
//   bus (slave)   : rx byte channel in, instruction memory write port out
//   core_resetb   : active-low core reset, high only in IDLE
//   busy          : loader in LEN0/LEN1/DATA/WRITE/RELEASE
//   done          : IDLE after a successful load
//   error         : loader in ERROR (bad length or timeout)
//   words_loaded  : words written in current/last load
module boot_loader #(
    parameter int IM_AW    = 10,
    parameter int TIMEOUT  = 65535,
    parameter int RST_HOLD = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_req,
    boot_loader_if.slave   bus,
    output logic           core_resetb,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [IM_AW:0] words_loaded
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [16:0]   MAX_LEN   = 17'(64'd1 << IM_AW);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_RELEASE, S_ERROR
    } state_t;

    state_t         state, state_n;
    logic [7:0]     len_lo;
    logic [15:0]    len;
    logic [15:0]    len_full;
    logic [1:0]     byte_idx;
    logic [23:0]    word_buf;
    logic [IM_AW:0] word_idx;
    logic [TW-1:0]  idle_cnt;
    logic [HW-1:0]  hold_cnt;
    logic           accept;
    logic           len_ok;
    logic           timeout_hit;
    logic           last_word;

    always_comb begin
        bus.rx_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
        busy         = (state != S_IDLE) && (state != S_ERROR);
        accept       = bus.rx_valid && bus.rx_ready;
        len_full     = {bus.rx_data, len_lo};
        len_ok       = (len_full != 16'd0) && ({1'b0, len_full} <= MAX_LEN);
        timeout_hit  = (idle_cnt == IDLE_LAST);
        last_word    = ((17'(word_idx) + 17'd1) == {1'b0, len});
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (load_req) state_n = S_LEN0;
            S_LEN0:    if (accept) state_n = S_LEN1;
            S_LEN1: begin
                if (accept)           state_n = len_ok ? S_DATA : S_ERROR;
                else if (timeout_hit) state_n = S_ERROR;
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx == 2'd3) state_n = S_WRITE;
                end else if (timeout_hit) begin
                    state_n = S_ERROR;
                end
            end
            S_WRITE:   state_n = last_word ? S_RELEASE : S_DATA;
            S_RELEASE: if (hold_cnt == HOLD_LAST) state_n = S_IDLE;
            S_ERROR:   if (load_req) state_n = S_LEN0;
            default:   state_n = S_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LEN0;
            len_lo       <= '0;
            len          <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            word_idx     <= '0;
            idle_cnt     <= '0;
            hold_cnt     <= '0;
            bus.im_we    <= 1'b0;
            bus.im_waddr <= '0;
            bus.im_wdata <= '0;
            core_resetb  <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state <= state_n;
            // Status outputs are registered copies of the next-state decode,
            // so they line up with the state they describe.
            bus.im_we   <= (state_n == S_WRITE);
            core_resetb <= (state_n == S_IDLE);
            done        <= (state_n == S_IDLE);
            error       <= (state_n == S_ERROR);

            if (((state == S_LEN1) || (state == S_DATA)) && !accept)
                idle_cnt <= idle_cnt + TW'(1);
            else
                idle_cnt <= '0;

            if (state == S_RELEASE) hold_cnt <= hold_cnt + HW'(1);
            else                    hold_cnt <= '0;

            if (state == S_LEN0) begin
                byte_idx <= '0;
                word_idx <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN0: len_lo <= bus.rx_data;
                    S_LEN1: len    <= len_full;
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.im_wdata <= {bus.rx_data, word_buf};
                                bus.im_waddr <= word_idx[IM_AW-1:0];
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) begin
                word_idx     <= word_idx + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end

            if (state_n == S_LEN0) words_loaded <= '0;
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: randomized byte timing and image
// contents, expected writes derived from the image (little-endian packing,
// consecutive addresses from 0), length legality and timing rules.
module tb_boot_loader;
    localparam int IM_AW    = 10;
    localparam int TIMEOUT  = 16;
    localparam int RST_HOLD = 4;
    localparam int MAXW     = 1 << IM_AW;

    logic           clk_tb = 1'b0;
    logic           reset;
    logic           load_req;
    logic           core_resetb;
    logic           busy;
    logic           done;
    logic           error;
    logic [IM_AW:0] words_loaded;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned last_we_cyc = 0;

    logic [IM_AW-1:0] wr_a[$];
    logic [31:0]      wr_d[$];
    logic [7:0]       img[$];

    boot_loader_if #(.IM_AW(IM_AW)) bus ();

    boot_loader #(.IM_AW(IM_AW), .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD)) dut (
        .clk          (clk_tb),
        .reset        (reset),
        .load_req     (load_req),
        .bus          (bus),
        .core_resetb  (core_resetb),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    always @(negedge clk_tb) begin
        if (bus.im_we === 1'b1) begin
            wr_a.push_back(bus.im_waddr);
            wr_d.push_back(bus.im_wdata);
            last_we_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    task automatic fill_img(input int unsigned n);
        img.delete();
        for (int unsigned i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    // Present one byte (optionally after gap idle cycles) and return once the
    // accepting edge has passed; w = cycles spent waiting for rx_ready.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap,
                             output int unsigned w);
        @(negedge clk_tb);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk_tb);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        w = 0;
        while (bus.rx_ready !== 1'b1 && w < 64) begin
            @(negedge clk_tb);
            w++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_byte: rx_ready stuck at %b, need 1", bus.rx_ready);
        end
        @(posedge clk_tb);
    endtask

    task automatic pulse_load_req;
        @(negedge clk_tb);
        bus.rx_valid = 1'b0;
        load_req = 1'b1;
        @(negedge clk_tb);
        load_req = 1'b0;
    endtask

    // Sends len header plus img; checks either the error outcome (illegal
    // length) or the full write sequence, release timing and final status.
    task automatic do_load(input string name, input int unsigned len,
                           input int unsigned gapmax, input bit b2b,
                           input int poke_idx);
        int unsigned w, n, exp_w;
        logic [15:0] l16;
        logic [31:0] exp_word;
        bit bad;
        wr_a.delete(); wr_d.delete();
        l16 = 16'(len);
        bad = (len == 0) || (len > MAXW);
        send_byte(l16[7:0],  $urandom_range(0, gapmax), w);
        send_byte(l16[15:8], $urandom_range(0, gapmax), w);
        if (bad) begin
            n = 0;
            do begin @(negedge clk_tb); n++; end while (error !== 1'b1 && n < 8);
            repeat (3) @(negedge clk_tb);  // rx_valid still high: must be ignored
            checks++; if (error !== 1'b1) begin errors++; $display("FAIL %s error: got %b need 1", name, error); end
            checks++; if (core_resetb !== 1'b0) begin errors++; $display("FAIL %s core_resetb: got %b need 0", name, core_resetb); end
            checks++; if (bus.rx_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s ready/busy: got %b/%b need 0/0", name, bus.rx_ready, busy); end
            checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL %s writes: got %0d need 0", name, wr_a.size()); end
            bus.rx_valid = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < 4 * len; i++) begin
            if (poke_idx >= 0 && i == poke_idx) pulse_load_req();
            send_byte(img[i], b2b ? 0 : $urandom_range(0, gapmax), w);
            exp_w = (i > 0 && i % 4 == 0) ? 1 : 0;
            if (b2b && i != poke_idx) begin
                checks++;
                if (w != exp_w) begin errors++; $display("FAIL %s stall byte %0d: got %0d need %0d", name, i, w, exp_w); end
            end
        end
        @(negedge clk_tb);
        bus.rx_valid = 1'b0;
        n = 0;
        while (core_resetb !== 1'b1 && n < 64) begin @(negedge clk_tb); n++; end
        checks++;
        if (core_resetb !== 1'b1) begin
            errors++; $display("FAIL %s release: core_resetb got %b need 1", name, core_resetb);
        end else if (cyc - last_we_cyc != RST_HOLD + 1) begin
            errors++; $display("FAIL %s release delay: got %0d need %0d", name, cyc - last_we_cyc, RST_HOLD + 1);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b need 1", name, done); end
        checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s error/busy: got %b/%b need 0/0", name, error, busy); end
        checks++; if (words_loaded !== (IM_AW+1)'(len)) begin errors++; $display("FAIL %s words_loaded: got %0d need %0d", name, words_loaded, len); end
        checks++; if (wr_a.size() != len) begin errors++; $display("FAIL %s write count: got %0d need %0d", name, wr_a.size(), len); end
        for (int unsigned k = 0; k < len && k < wr_a.size(); k++) begin
            exp_word = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
            checks++;
            if (wr_a[k] !== IM_AW'(k) || wr_d[k] !== exp_word) begin
                errors++;
                $display("FAIL %s word %0d: got [%h]=%h need [%h]=%h", name, k, wr_a[k], wr_d[k], IM_AW'(k), exp_word);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; load_req = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        repeat (3) @(negedge clk_tb);
        checks++; if (core_resetb !== 1'b0 || bus.im_we !== 1'b0) begin errors++; $display("FAIL reset core_resetb/im_we: got %b/%b need 0/0", core_resetb, bus.im_we); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset done/error: got %b/%b need 0/0", done, error); end
        checks++; if (words_loaded !== '0) begin errors++; $display("FAIL reset words_loaded: got %0d need 0", words_loaded); end
        checks++; if (busy !== 1'b1 || bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset busy/rx_ready: got %b/%b need 1/1", busy, bus.rx_ready); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        img.delete();
        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
        do_load("basic", 2, 3, 1'b0, -1);
    endtask

    task automatic test_zero_len;
        pulse_load_req();
        do_load("zero_len", 0, 2, 1'b0, -1);
        pulse_load_req();
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_len exit: error/busy got %b/%b need 0/1", error, busy); end
        fill_img(4);
        do_load("one_word", 1, 3, 1'b0, -1);
    endtask

    task automatic test_len_bounds;
        pulse_load_req();
        do_load("len_1025", MAXW + 1, 2, 1'b0, -1);
        pulse_load_req();
        fill_img(4 * MAXW);
        do_load("len_1024", MAXW, 2, 1'b0, -1);
        checks++;
        if (wr_a.size() == 0 || wr_a[wr_a.size()-1] !== IM_AW'(MAXW - 1)) begin
            errors++; $display("FAIL len_1024 last addr: got %0d writes need last addr %h", wr_a.size(), MAXW - 1);
        end
    endtask

    task automatic test_timeout;
        int unsigned w;
        wr_a.delete(); wr_d.delete();
        pulse_load_req();
        send_byte(8'h01, $urandom_range(0, 3), w);
        send_byte(8'h00, $urandom_range(0, 3), w);
        send_byte(8'($urandom), $urandom_range(0, 3), w);
        send_byte(8'($urandom), $urandom_range(0, 3), w);
        @(negedge clk_tb);
        bus.rx_valid = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk_tb);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout early: error/busy got %b/%b need 0/1", error, busy); end
        @(negedge clk_tb);
        checks++; if (error !== 1'b1 || core_resetb !== 1'b0) begin errors++; $display("FAIL timeout: error/core_resetb got %b/%b need 1/0", error, core_resetb); end
        checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL timeout writes: got %0d need 0", wr_a.size()); end
    endtask

    task automatic test_reset_mid;
        int unsigned w;
        pulse_load_req();
        send_byte(8'h01, 0, w);
        send_byte(8'h00, 0, w);
        for (int unsigned i = 0; i < 3; i++) send_byte(8'($urandom), 1, w);
        @(negedge clk_tb);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_tb);
        reset = 1'b0;
        checks++; if (busy !== 1'b1 || bus.rx_ready !== 1'b1 || core_resetb !== 1'b0) begin errors++; $display("FAIL reset_mid state: busy/rx_ready/core_resetb got %b/%b/%b need 1/1/0", busy, bus.rx_ready, core_resetb); end
        checks++; if (words_loaded !== '0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid status: words_loaded/done got %0d/%b need 0/0", words_loaded, done); end
        fill_img(4);
        do_load("after_reset", 1, 2, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        pulse_load_req();
        checks++; if (core_resetb !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reload: core_resetb/done/busy got %b/%b/%b need 0/0/1", core_resetb, done, busy); end
        checks++; if (words_loaded !== '0) begin errors++; $display("FAIL reload words_loaded: got %0d need 0", words_loaded); end
        fill_img(12);
        do_load("back_to_back", 3, 0, 1'b1, 6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_len_bounds();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
